sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequences and shares the single external 8-bit asynchronous SRAM (19-bit address, shared DQ bus, active-low WE) between two requesters: the Oric core memory port and a DMA port used by loaders (ROM/tape/disk image transfer from the SPI side). It sits between the core and the board SRAM pins, serialising accesses with a fixed-length timed cycle, a req/ack handshake per port, and a registered read-data return. The core port has priority; an optional starvation guard bounds DMA wait.

## Interface

- ACCESS_CYCLES, 2: clock cycles the SRAM address/control are held per access; legal range 2..15.
- STARVE_LIMIT, 8: consecutive core grants tolerated while DMA is pending (guard build only); legal range 1..255.

- clk_sys  in  1  system clock; all logic on its rising edge.
- res_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high.
- cpu_a  in  16  core address; mapped to SRAM {3'b000, cpu_a}.
- cpu_d  in  8  core write data.
- cpu_q  out  8  core read data; valid from cpu_ack cycle until next core read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req  in  1  DMA request; held until dma_ack.
- dma_we  in  1  1 = write, 0 = read.
- dma_a  in  19  DMA full SRAM address.
- dma_d  in  8  DMA write data.
- dma_q  out  8  DMA read data; valid from dma_ack cycle until next DMA read completes.
- dma_ack  out  1  one-cycle completion pulse.
- sram_a  out  19  SRAM address.
- sram_dout  out  8  data to DQ pins.
- sram_doe  out  1  DQ output enable (1 = FPGA drives DQ).
- sram_we_n  out  1  SRAM write enable, active low.
- sram_din  in  8  data from DQ pins.
- busy  out  1  high while any access is in progress (LED/status).

## Operation

- States: IDLE, ACT, END.
- IDLE: sample cpu_req/dma_req. Grant core if cpu_req, else DMA if dma_req (guard override below). On grant register address, data, we, owner; load cycle counter to ACCESS_CYCLES-1; go ACT. No request: stay IDLE.
- ACT: sram_a = registered address. Write: sram_doe=1, sram_dout = registered data, sram_we_n=0 in every ACT cycle except the last (address/data hold). Read: sram_doe=0, sram_we_n=1; sram_din captured into owner's q register on the last ACT cycle. Counter decrements; at 0 go END.
- END: pulse owner's ack for one cycle; address held, sram_we_n=1; write keeps sram_doe=1 for this cycle (data hold), then 0. Go IDLE.
- Inputs only sampled in IDLE; changes during ACT/END ignored. Requester must drop req on the edge ending the ack cycle; a req still high in IDLE is a new transaction.
- q of the non-owner port never changes. Writes never alter cpu_q/dma_q.
- busy = (state != IDLE).
- Reset (async, any state): state IDLE, sram_a 0, sram_dout 0, sram_doe 0, sram_we_n 1, cpu_q/dma_q 0, acks 0, busy 0, guard counter 0. In-flight access abandoned with no ack.

## Timing

- Request high in IDLE cycle t -> ACT cycles t+1..t+ACCESS_CYCLES -> ack at t+ACCESS_CYCLES+1 -> IDLE at t+ACCESS_CYCLES+2.
- Default ACCESS_CYCLES=2: ack 3 cycles after grant; max throughput one access per 4 cycles.
- Simultaneous cpu_req and dma_req in IDLE: core wins (unless guard trips); DMA granted in the next IDLE with no cpu_req.
- sram_we_n low width = ACCESS_CYCLES-1 cycles; address and data stable 1 cycle before and after.
- Read data sampled from sram_din at end of last ACT cycle; sram_din treated as settled by then.

## Configuration

- SRAM_ARB_STARVE_GUARD_EN defined: 8-bit counter increments on each core grant made while dma_req is high; clears on DMA grant or when dma_req low in IDLE. When counter = STARVE_LIMIT and dma_req high in IDLE, DMA is granted even if cpu_req high.
- Not defined: strict core priority; counter and STARVE_LIMIT unused; DMA may starve indefinitely.

## Test plan

- Core write 0x5A to cpu_a 0x1234, then read -> sram_a 0x01234, sram_we_n low exactly 1 cycle, cpu_ack 3 cycles after req sampled; read returns cpu_q 0x5A.
- DMA write 0xC3 to 0x7FFFF, read back -> dma_q 0xC3, cpu_q unchanged, sram_a 0x7FFFF throughout access.
- cpu_req and dma_req raised same cycle -> core acked first, DMA acked exactly 4 cycles later.
- Guard build, STARVE_LIMIT=3, cpu_req re-raised continuously, dma_req held -> 3 core acks then DMA ack; non-guard build -> no dma_ack while core keeps requesting.
- res_n pulsed low in middle ACT cycle of a write -> sram_we_n 1, sram_doe 0, busy 0 immediately; no ack; next request served normally.
- ACCESS_CYCLES=4 -> sram_we_n low 3 cycles, ack 5 cycles after grant.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 8-bit async SRAM between the core port
// (priority) and a DMA loader port. Each access is a fixed ACCESS_CYCLES-long
// timed cycle followed by a one-cycle ack. The outputs hold their last values
// between accesses.
// Optional build macro SRAM_ARB_STARVE_GUARD_EN bounds the time the DMA port
// waits. With the macro set, the DMA port wins after STARVE_LIMIT back-to-back
// core grants made while dma_req was high.
// ACCESS_CYCLES legal range 2..15; STARVE_LIMIT legal range 1..255.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
`ifdef SRAM_ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 8
`endif
) (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_a,
  input  logic [7:0]  dma_d,
  output logic [7:0]  dma_q,
  output logic        dma_ack,
  output logic [18:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  output logic        sram_we_n,
  input  logic [7:0]  sram_din,
  output logic        busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACT, S_END} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                we_r, we_nxt;
  logic                own_dma, own_dma_nxt;
  logic [ADDR_W-1:0]   sram_a_nxt;
  logic [DATA_W-1:0]   sram_dout_nxt;
  logic                sram_doe_nxt, sram_we_n_nxt;
  logic                cpu_ack_nxt, dma_ack_nxt, busy_nxt;
  logic [DATA_W-1:0]   cpu_q_nxt, dma_q_nxt;
  logic                starve_trip_c;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt, starve_cnt_nxt;
  assign starve_trip_c = dma_req && (starve_cnt == STARVE_MAX);
`else
  assign starve_trip_c = 1'b0;
`endif

  // Next-state and next-output logic; the output registers hold their values unless changed here.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    we_nxt        = we_r;
    own_dma_nxt   = own_dma;
    sram_a_nxt    = sram_a;
    sram_dout_nxt = sram_dout;
    sram_doe_nxt  = sram_doe;
    sram_we_n_nxt = sram_we_n;
    cpu_q_nxt     = cpu_q;
    dma_q_nxt     = dma_q;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    starve_cnt_nxt = starve_cnt;
`endif
    case (state)
      S_IDLE: begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
        if (!dma_req) starve_cnt_nxt = '0;
`endif
        if (starve_trip_c || (dma_req && !cpu_req)) begin
          state_nxt     = S_ACT;
          cnt_nxt       = CNT_LOAD;
          own_dma_nxt   = 1'b1;
          we_nxt        = dma_we;
          sram_a_nxt    = dma_a;
          sram_dout_nxt = dma_d;
          sram_doe_nxt  = dma_we;
          sram_we_n_nxt = ~dma_we;
`ifdef SRAM_ARB_STARVE_GUARD_EN
          starve_cnt_nxt = '0;
`endif
        end else if (cpu_req) begin
          state_nxt     = S_ACT;
          cnt_nxt       = CNT_LOAD;
          own_dma_nxt   = 1'b0;
          we_nxt        = cpu_we;
          sram_a_nxt    = {3'b000, cpu_a};
          sram_dout_nxt = cpu_d;
          sram_doe_nxt  = cpu_we;
          sram_we_n_nxt = ~cpu_we;
`ifdef SRAM_ARB_STARVE_GUARD_EN
          if (dma_req) starve_cnt_nxt = starve_cnt + 8'd1;
`endif
        end
      end
      S_ACT: begin
        if (cnt == '0) begin
          state_nxt     = S_END;
          sram_we_n_nxt = 1'b1;
          cpu_ack_nxt   = ~own_dma;
          dma_ack_nxt   = own_dma;
          if (!we_r) begin
            if (own_dma) dma_q_nxt = sram_din;
            else         cpu_q_nxt = sram_din;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          // WE rises one cycle before the last ACT cycle ends, so address and data stay stable around it
          sram_we_n_nxt = ~we_r | (cnt == CNT_W'(1));
        end
      end
      S_END: begin
        state_nxt     = S_IDLE;
        sram_doe_nxt  = 1'b0;
        sram_we_n_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State register; every port output is registered here as well.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_r      <= 1'b0;
      own_dma   <= 1'b0;
      sram_a    <= '0;
      sram_dout <= '0;
      sram_doe  <= 1'b0;
      sram_we_n <= 1'b1;
      cpu_q     <= '0;
      dma_q     <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      we_r      <= we_nxt;
      own_dma   <= own_dma_nxt;
      sram_a    <= sram_a_nxt;
      sram_dout <= sram_dout_nxt;
      sram_doe  <= sram_doe_nxt;
      sram_we_n <= sram_we_n_nxt;
      cpu_q     <= cpu_q_nxt;
      dma_q     <= dma_q_nxt;
      cpu_ack   <= cpu_ack_nxt;
      dma_ack   <= dma_ack_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  // Counts core grants made while DMA is waiting.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus hand-written sequences for the
// sram_arbiter. The bench plays the SRAM by driving sram_din. A second
// instance is built with ACCESS_CYCLES=4.
module tb_sram_arbiter;

  logic        clk_sys, res_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d, dma_d, sram_din;
  logic [18:0] dma_a;
  logic [7:0]  cpu_q, dma_q, sram_dout;
  logic        cpu_ack, dma_ack, sram_doe, sram_we_n, busy;
  logic [18:0] sram_a;

  logic        c4_req, c4_we;
  logic [15:0] c4_a;
  logic [7:0]  c4_d, din4, q4_cpu, q4_dma, dout4;
  logic        ack4_cpu, ack4_dma, doe4, we_n4, busy4;
  logic [18:0] a4;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(
    .ACCESS_CYCLES(2)
`ifdef SRAM_ARB_STARVE_GUARD_EN
    , .STARVE_LIMIT(3)
`endif
  ) u_dut (
    .clk_sys(clk_sys), .res_n(res_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_d(dma_d),
    .dma_q(dma_q), .dma_ack(dma_ack),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_we_n(sram_we_n), .sram_din(sram_din), .busy(busy)
  );

  sram_arbiter #(.ACCESS_CYCLES(4)) u_dut4 (
    .clk_sys(clk_sys), .res_n(res_n),
    .cpu_req(c4_req), .cpu_we(c4_we), .cpu_a(c4_a), .cpu_d(c4_d),
    .cpu_q(q4_cpu), .cpu_ack(ack4_cpu),
    .dma_req(1'b0), .dma_we(1'b0), .dma_a(19'h0), .dma_d(8'h00),
    .dma_q(q4_dma), .dma_ack(ack4_dma),
    .sram_a(a4), .sram_dout(dout4), .sram_doe(doe4),
    .sram_we_n(we_n4), .sram_din(din4), .busy(busy4)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        creq, cwe;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic        dreq, dwe;
    logic [18:0] da;
    logic [7:0]  dd, din;
    logic [18:0] ea;
    logic [7:0]  edout;
    logic        edoe, ewen, ecack, edack;
    logic [7:0]  ecq, edq;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
    input logic creq, input logic cwe, input logic [15:0] ca, input logic [7:0] cd,
    input logic dreq, input logic dwe, input logic [18:0] da, input logic [7:0] dd,
    input logic [7:0] din,
    input logic [18:0] ea, input logic [7:0] edout, input logic edoe, input logic ewen,
    input logic ecack, input logic edack, input logic [7:0] ecq, input logic [7:0] edq,
    input logic ebusy);
    vec_t v;
    v = '{creq, cwe, ca, cd, dreq, dwe, da, dd, din,
          ea, edout, edoe, ewen, ecack, edack, ecq, edq, ebusy};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  function automatic logic [47:0] outs();
    return {sram_a, sram_dout, sram_doe, sram_we_n, cpu_ack, dma_ack, cpu_q, dma_q, busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cack, n_dack, n, low_cnt, ack_at;
    logic [3:0] order;
    logic addr_ok;

    res_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_d = '0;
    dma_req = 0; dma_we = 0; dma_a = '0; dma_d = '0; sram_din = '0;
    c4_req = 0; c4_we = 0; c4_a = '0; c4_d = '0; din4 = '0;

    // Core write 0x5A to 0x1234, then read it back
    add_vec(1,1,16'h1234,8'h5A, 0,0,19'h0,8'h00, 8'h00, 19'h01234,8'h5A,1,0, 0,0,8'h00,8'h00,1);
    add_vec(1,1,16'h1234,8'h5A, 0,0,19'h0,8'h00, 8'h00, 19'h01234,8'h5A,1,1, 0,0,8'h00,8'h00,1);
    add_vec(1,1,16'h1234,8'h5A, 0,0,19'h0,8'h00, 8'h00, 19'h01234,8'h5A,1,1, 1,0,8'h00,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 0,0,19'h0,8'h00, 8'h00, 19'h01234,8'h5A,0,1, 0,0,8'h00,8'h00,0);
    add_vec(1,0,16'h1234,8'h00, 0,0,19'h0,8'h00, 8'hEE, 19'h01234,8'h00,0,1, 0,0,8'h00,8'h00,1);
    add_vec(1,0,16'h1234,8'h00, 0,0,19'h0,8'h00, 8'hEE, 19'h01234,8'h00,0,1, 0,0,8'h00,8'h00,1);
    add_vec(1,0,16'h1234,8'h00, 0,0,19'h0,8'h00, 8'h5A, 19'h01234,8'h00,0,1, 1,0,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 0,0,19'h0,8'h00, 8'h00, 19'h01234,8'h00,0,1, 0,0,8'h5A,8'h00,0);
    // DMA write 0xC3 to top address; sram_din noise must not reach any q
    add_vec(0,0,16'h0000,8'h00, 1,1,19'h7FFFF,8'hC3, 8'h99, 19'h7FFFF,8'hC3,1,0, 0,0,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 1,1,19'h7FFFF,8'hC3, 8'h99, 19'h7FFFF,8'hC3,1,1, 0,0,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 1,1,19'h7FFFF,8'hC3, 8'h99, 19'h7FFFF,8'hC3,1,1, 0,1,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 0,0,19'h0,8'h00, 8'h00, 19'h7FFFF,8'hC3,0,1, 0,0,8'h5A,8'h00,0);
    // DMA read back; cpu_q must stay 0x5A
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h7FFFF,8'h00, 8'h77, 19'h7FFFF,8'h00,0,1, 0,0,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h7FFFF,8'h00, 8'h77, 19'h7FFFF,8'h00,0,1, 0,0,8'h5A,8'h00,1);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h7FFFF,8'h00, 8'hC3, 19'h7FFFF,8'h00,0,1, 0,1,8'h5A,8'hC3,1);
    add_vec(0,0,16'h0000,8'h00, 0,0,19'h0,8'h00, 8'h00, 19'h7FFFF,8'h00,0,1, 0,0,8'h5A,8'hC3,0);
    // Simultaneous requests: core first, DMA acked 4 cycles later
    add_vec(1,0,16'h0010,8'h00, 1,0,19'h00020,8'h00, 8'h11, 19'h00010,8'h00,0,1, 0,0,8'h5A,8'hC3,1);
    add_vec(1,0,16'h0010,8'h00, 1,0,19'h00020,8'h00, 8'h11, 19'h00010,8'h00,0,1, 0,0,8'h5A,8'hC3,1);
    add_vec(1,0,16'h0010,8'h00, 1,0,19'h00020,8'h00, 8'h22, 19'h00010,8'h00,0,1, 1,0,8'h22,8'hC3,1);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h00020,8'h00, 8'h33, 19'h00010,8'h00,0,1, 0,0,8'h22,8'hC3,0);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h00020,8'h00, 8'h33, 19'h00020,8'h00,0,1, 0,0,8'h22,8'hC3,1);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h00020,8'h00, 8'h33, 19'h00020,8'h00,0,1, 0,0,8'h22,8'hC3,1);
    add_vec(0,0,16'h0000,8'h00, 1,0,19'h00020,8'h00, 8'h44, 19'h00020,8'h00,0,1, 0,1,8'h22,8'h44,1);
    add_vec(0,0,16'h0000,8'h00, 0,0,19'h0,8'h00, 8'h00, 19'h00020,8'h00,0,1, 0,0,8'h22,8'h44,0);

    repeat (2) @(negedge clk_sys);
    check("reset_state", 64'(outs()),
          64'({19'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}));
    check("reset_state_ac4", 64'({a4, dout4, doe4, we_n4, ack4_cpu, busy4}),
          64'({19'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    res_n = 1'b1;

    // Apply the vector table: each vector is sampled at one rising edge, then checked.
    for (int i = 0; i < vecs.size(); i++) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_a = vecs[i].ca; cpu_d = vecs[i].cd;
      dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_a = vecs[i].da; dma_d = vecs[i].dd;
      sram_din = vecs[i].din;
      tick();
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].ea, vecs[i].edout, vecs[i].edoe, vecs[i].ewen, vecs[i].ecack,
                 vecs[i].edack, vecs[i].ecq, vecs[i].edq, vecs[i].ebusy}));
    end

    // Both ports requesting continuously for 40 cycles
    cpu_req = 1; cpu_we = 0; cpu_a = 16'h0100;
    dma_req = 1; dma_we = 0; dma_a = 19'h00200;
    n_cack = 0; n_dack = 0; order = '0; n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        if (n < 4) order[n] = dma_ack;
        n++;
      end
      if (cpu_ack) n_cack++;
      if (dma_ack) n_dack++;
    end
    cpu_req = 0; dma_req = 0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    check("starve_cpu_acks", 64'(n_cack), 64'd8);
    check("starve_dma_acks", 64'(n_dack), 64'd2);
    check("starve_order", 64'(order), 64'b1000);
`else
    check("strict_cpu_acks", 64'(n_cack), 64'd10);
    check("strict_dma_acks", 64'(n_dack), 64'd0);
`endif
    tick();
    check("starve_idle_after", 64'(busy), 64'd0);

    // Reset pulsed during the write-enable cycle of a core write
    cpu_req = 1; cpu_we = 1; cpu_a = 16'h4321; cpu_d = 8'hA5;
    tick();
    check("rst_pre_we_low", 64'({sram_we_n, sram_doe, busy}), 64'b011);
    res_n = 1'b0;
    cpu_req = 0;
    #1;
    check("rst_async", 64'({sram_we_n, sram_doe, busy, cpu_ack, dma_ack}), 64'b10000);
    @(negedge clk_sys);
    res_n = 1'b1;
    n_cack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cpu_ack || dma_ack) n_cack++;
    end
    check("rst_no_ack", 64'(n_cack), 64'd0);
    cpu_req = 1; cpu_we = 0; cpu_a = 16'h4321; sram_din = 8'h3C;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (cpu_ack) begin n = c; break; end
    end
    cpu_req = 0;
    check("rst_recover_latency", 64'(n), 64'd3);
    check("rst_recover_q", 64'(cpu_q), 64'h3C);

    // ACCESS_CYCLES=4 instance: write then read
    c4_req = 1; c4_we = 1; c4_a = 16'hBEEF; c4_d = 8'h96; din4 = 8'h00;
    low_cnt = 0; ack_at = 0; addr_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (!we_n4) low_cnt++;
      if (busy4 && a4 != 19'h0BEEF) addr_ok = 1'b0;
      if (ack4_cpu) begin ack_at = c; break; end
    end
    c4_req = 0;
    check("ac4_we_low_width", 64'(low_cnt), 64'd3);
    check("ac4_write_ack", 64'(ack_at), 64'd5);
    check("ac4_addr_stable", 64'(addr_ok), 64'd1);
    tick();
    c4_req = 1; c4_we = 0; din4 = 8'h96;
    ack_at = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack4_cpu) begin ack_at = c; break; end
    end
    c4_req = 0;
    check("ac4_read_ack", 64'(ack_at), 64'd5);
    check("ac4_read_q", 64'({q4_cpu, q4_dma}), 64'h9600);
    tick();
    check("ac4_idle", 64'({busy4, doe4, we_n4}), 64'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
